// File: rtl/led_pattern_gen.sv
// Five-LED pattern generator: debounced button cycles ALL_ON/SCAN/COUNT/BLINK, 4-bit PWM dims.
// Latency: LEDs lag pattern/PWM by 1 cycle; button press reaches mode DEBOUNCE_CYC+3 edges after sampling.
// Backpressure: none, free-running; the press pulse overrides a coincident pattern tick.
module led_pattern_gen #(
    parameter int unsigned TICK_DIV     = 1200000,
    parameter int unsigned DEBOUNCE_CYC = 120000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn,
    input  logic [3:0] brightness,
    output logic [1:0] mode,
    output logic       LED0,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic       LED4
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ALL_ON = 2'd0,
        SCAN   = 2'd1,
        COUNT  = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    logic          sync1_q, sync2_q;
    logic          acc_q, acc_d;
    logic          press_q, press_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    mode_e         state_q, state_d;
    logic [4:0]    pat_q, pat_d;
    logic          dir_up_q, dir_up_d;
    logic [3:0]    pwm_cnt_q;
    logic          pwm_on;
    logic [4:0]    led_q, led_d;

    function automatic logic [4:0] init_pat(input mode_e m);
        case (m)
            ALL_ON:  return 5'b11111;
            SCAN:    return 5'b00001;
            COUNT:   return 5'b00000;
            default: return 5'b10101;
        endcase
    endfunction

    // The counter only runs while the synced level disagrees with the accepted one.
    always_comb begin
        acc_d    = acc_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == acc_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DW'(DEBOUNCE_CYC)) begin
            acc_d    = ~acc_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
        press_d = acc_d & ~acc_q;
    end

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        if (press_q) begin
            case (state_q)
                ALL_ON:  state_d = SCAN;
                SCAN:    state_d = COUNT;
                COUNT:   state_d = BLINK;
                default: state_d = ALL_ON;
            endcase
        end
    end

    always_comb begin
        pat_d      = pat_q;
        dir_up_d   = dir_up_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        if (press_q) begin
            pat_d      = init_pat(state_d);
            dir_up_d   = 1'b1;
            tick_cnt_d = '0;
        end else if (tick) begin
            case (state_q)
                ALL_ON: pat_d = 5'b11111;
                SCAN: begin
                    if (dir_up_q) begin
                        if (pat_q[4]) begin
                            pat_d    = 5'b01000;
                            dir_up_d = 1'b0;
                        end else begin
                            pat_d = pat_q << 1;
                        end
                    end else begin
                        if (pat_q[0]) begin
                            pat_d    = 5'b00010;
                            dir_up_d = 1'b1;
                        end else begin
                            pat_d = pat_q >> 1;
                        end
                    end
                end
                COUNT:   pat_d = pat_q + 5'd1;
                default: pat_d = ~pat_q;
            endcase
        end
    end

    assign pwm_on = (brightness == 4'd15) | (pwm_cnt_q < brightness);
    assign led_d  = pat_q & {5{pwm_on}};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            acc_q      <= 1'b0;
            press_q    <= 1'b0;
            db_cnt_q   <= '0;
            tick_cnt_q <= '0;
            state_q    <= ALL_ON;
            pat_q      <= 5'b11111;
            dir_up_q   <= 1'b1;
            pwm_cnt_q  <= 4'd0;
            led_q      <= 5'b00000;
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            acc_q      <= acc_d;
            press_q    <= press_d;
            db_cnt_q   <= db_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            pat_q      <= pat_d;
            dir_up_q   <= dir_up_d;
            pwm_cnt_q  <= pwm_cnt_q + 4'd1;
            led_q      <= led_d;
        end
    end

    assign mode = state_q;
    assign LED0 = led_q[0];
    assign LED1 = led_q[1];
    assign LED2 = led_q[2];
    assign LED3 = led_q[3];
    assign LED4 = led_q[4];

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a short tick period and debounce window.
module tb_led_pattern_gen;
    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk;
    logic       rstn;
    logic       btn;
    logic [3:0] brightness;
    logic [1:0] mode;
    logic       LED0, LED1, LED2, LED3, LED4;
    logic [4:0] leds;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_press_edge = 0;

    assign leds = {LED4, LED3, LED2, LED1, LED0};

    led_pattern_gen #(
        .TICK_DIV    (TD),
        .DEBOUNCE_CYC(DB)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .btn       (btn),
        .brightness(brightness),
        .mode      (mode),
        .LED0      (LED0),
        .LED1      (LED1),
        .LED2      (LED2),
        .LED3      (LED3),
        .LED4      (LED4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge; returns at the negedge just after the edge where mode advanced.
    task automatic press_button();
        btn = 1'b1;
        repeat (DB + 4) @(posedge clk);
        @(negedge clk);
        btn = 1'b0;
        last_press_edge = cyc;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        btn = 1'b0;
        brightness = 4'd15;
        repeat (3) @(negedge clk);
        checks++;
        if (leds !== 5'b00000) begin
            errors++;
            $display("FAIL reset_leds: got %b expected %b", leds, 5'b00000);
        end
        checks++;
        if (mode !== 2'd0) begin
            errors++;
            $display("FAIL reset_mode: got %0d expected %0d", mode, 0);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (leds !== 5'b11111 || mode !== 2'd0) begin
            errors++;
            $display("FAIL first_edge: got leds=%b mode=%0d expected leds=11111 mode=0", leds, mode);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (leds !== 5'b11111 || mode !== 2'd0) begin
                errors++;
                $display("FAIL all_on_steady[%0d]: got leds=%b mode=%0d expected leds=11111 mode=0", i, leds, mode);
            end
        end
    endtask

    task automatic test_debounce_glitch();
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (mode !== 2'd0) begin
                errors++;
                $display("FAIL glitch_mode[%0d]: got %0d expected %0d", i, mode, 0);
            end
        end
    endtask

    task automatic test_debounce_hold();
        logic [1:0] exp;
        btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp = (k >= DB + 4) ? 2'd1 : 2'd0;
            checks++;
            if (mode !== exp) begin
                errors++;
                $display("FAIL hold_mode[%0d]: got %0d expected %0d", k, mode, exp);
            end
        end
        btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (mode !== 2'd1) begin
                errors++;
                $display("FAIL release_mode[%0d]: got %0d expected %0d", i, mode, 1);
            end
        end
    endtask

    task automatic test_scan();
        logic [4:0] seq [0:9];
        seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
                5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00010};
        apply_reset();
        press_button();
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("FAIL scan_mode: got %0d expected %0d", mode, 1);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (leds !== seq[k/4]) begin
                errors++;
                $display("FAIL scan_seq[%0d]: got %b expected %b", k, leds, seq[k/4]);
            end
        end
    endtask

    task automatic test_count();
        logic [4:0] exp;
        repeat (4) @(negedge clk);
        press_button();
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("FAIL count_mode: got %0d expected %0d", mode, 2);
        end
        for (int k = 0; k < 33; k++) begin
            exp = k[4:0];
            for (int j = 0; j < TD; j++) begin
                @(negedge clk);
                checks++;
                if (leds !== exp) begin
                    errors++;
                    $display("FAIL count_step[%0d.%0d]: got %b expected %b", k, j, leds, exp);
                end
            end
        end
    endtask

    task automatic test_press_on_tick();
        int guard;
        guard = 0;
        while (((cyc + DB + 4 - last_press_edge) % TD) != 0 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        press_button();
        checks++;
        if (mode !== 2'd3) begin
            errors++;
            $display("FAIL tick_press_mode: got %0d expected %0d", mode, 3);
        end
        for (int j = 0; j < TD; j++) begin
            @(negedge clk);
            checks++;
            if (leds !== 5'b10101) begin
                errors++;
                $display("FAIL blink_first[%0d]: got %b expected %b", j, leds, 5'b10101);
            end
        end
        @(negedge clk);
        checks++;
        if (leds !== 5'b01010) begin
            errors++;
            $display("FAIL blink_toggle: got %b expected %b", leds, 5'b01010);
        end
    endtask

    task automatic test_pwm();
        int cnt [5];
        repeat (10) @(negedge clk);
        press_button();
        checks++;
        if (mode !== 2'd0) begin
            errors++;
            $display("FAIL pwm_mode: got %0d expected %0d", mode, 0);
        end
        brightness = 4'd4;
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 5; b++) cnt[b] = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                for (int b = 0; b < 5; b++) cnt[b] += int'(leds[b]);
            end
            for (int b = 0; b < 5; b++) begin
                checks++;
                if (cnt[b] != 4) begin
                    errors++;
                    $display("FAIL pwm4_led%0d_win%0d: got %0d high cycles expected %0d", b, w, cnt[b], 4);
                end
            end
        end
        brightness = 4'd0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++;
            if (leds !== 5'b00000) begin
                errors++;
                $display("FAIL pwm0[%0d]: got %b expected %b", i, leds, 5'b00000);
            end
        end
        brightness = 4'd15;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++;
            if (leds !== 5'b11111) begin
                errors++;
                $display("FAIL pwm15[%0d]: got %b expected %b", i, leds, 5'b11111);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        press_button();
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("FAIL mid_scan_mode: got %0d expected %0d", mode, 1);
        end
        repeat (13) @(negedge clk);
        checks++;
        if (leds !== 5'b01000) begin
            errors++;
            $display("FAIL mid_scan_pat: got %b expected %b", leds, 5'b01000);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (leds !== 5'b00000 || mode !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got leds=%b mode=%0d expected leds=00000 mode=0", leds, mode);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (leds !== 5'b11111 || mode !== 2'd0) begin
            errors++;
            $display("FAIL post_reset: got leds=%b mode=%0d expected leds=11111 mode=0", leds, mode);
        end
    endtask

    initial begin
        test_reset();
        test_debounce_glitch();
        test_debounce_hold();
        test_scan();
        test_count();
        test_press_on_tick();
        test_pwm();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
